// File: rtl/gbuff_reader_if.sv
// rtl/gbuff_reader_if.sv - command, buffer-port and output-stream bundle of gbuff_reader
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface gbuff_reader_if #(
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int WORD_WIDTH = `WORD_WIDTH,
   parameter int LEN_WIDTH  = 16
);
   logic                  start_i;
   logic [ADDR_WIDTH-1:0] base_addr_i;
   logic [LEN_WIDTH-1:0]  len_i;
   logic [ADDR_WIDTH-1:0] stride_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  gbuff_wr_en_o;
   logic [ADDR_WIDTH-1:0] gbuff_addr_o;
   logic [WORD_WIDTH-1:0] gbuff_data_i;
   logic [WORD_WIDTH-1:0] data_o;
   logic                  valid_o;
   logic                  ready_i;

   modport master (
      input  start_i, base_addr_i, len_i, stride_i, gbuff_data_i, ready_i,
      output busy_o, done_o, gbuff_wr_en_o, gbuff_addr_o, data_o, valid_o
   );

   modport slave (
      output start_i, base_addr_i, len_i, stride_i, gbuff_data_i, ready_i,
      input  busy_o, done_o, gbuff_wr_en_o, gbuff_addr_o, data_o, valid_o
   );
endinterface

// File: rtl/gbuff_reader.sv
// rtl/gbuff_reader.sv - strided global-buffer reader with credit-tracked output FIFO
// Optional abort port enabled by defining GBUFF_READER_ABORT_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module gbuff_reader #(
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int WORD_WIDTH = `WORD_WIDTH,
   parameter int LEN_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
`ifdef GBUFF_READER_ABORT_EN
   input  logic abort_i,
`endif
   gbuff_reader_if.master bus
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e                state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
   logic [LEN_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
   logic [ADDR_WIDTH-1:0] stride_q, stride_d;
   logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  inflight_q, inflight_d;
   logic [WORD_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
   logic                  issue, push, pop, kill, abort;

`ifdef GBUFF_READER_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      issue_cnt_d = issue_cnt_q;
      pop_cnt_d   = pop_cnt_q;
      stride_d    = stride_q;
      next_addr_d = next_addr_q;
      addr_d      = addr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      inflight_d  = 1'b0;
      issue       = 1'b0;
      kill        = abort && (state_q == S_RUN);
      push        = inflight_q && !kill;
      pop         = (count_q != '0) && bus.ready_i && !kill;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               len_d       = bus.len_i;
               stride_d    = bus.stride_i;
               next_addr_d = bus.base_addr_i;
               issue_cnt_d = '0;
               pop_cnt_d   = '0;
               state_d     = (bus.len_i == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            // A read only goes out if a FIFO slot is guaranteed for its return data.
            issue = !kill && (issue_cnt_q < len_q) &&
                    ((32'(count_q) + 32'(inflight_q)) < 32'(FIFO_DEPTH));
            if (pop && (pop_cnt_q == len_q - LEN_WIDTH'(1)))
               state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (issue) begin
         addr_d      = next_addr_q;
         next_addr_d = next_addr_q + stride_q;
         issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
      end
      inflight_d = issue;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop) begin
         rd_ptr_d  = ptr_inc(rd_ptr_q);
         pop_cnt_d = pop_cnt_q + LEN_WIDTH'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      if (kill) begin
         state_d  = S_IDLE;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         issue_cnt_q <= '0;
         pop_cnt_q   <= '0;
         stride_q    <= '0;
         next_addr_q <= '0;
         addr_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         inflight_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         issue_cnt_q <= issue_cnt_d;
         pop_cnt_q   <= pop_cnt_d;
         stride_q    <= stride_d;
         next_addr_q <= next_addr_d;
         addr_q      <= addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
      end
   end

   // Storage is not reset; data_o is masked by valid so stale entries never leak.
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem_q[wr_ptr_q] <= bus.gbuff_data_i;
   end

   assign bus.gbuff_addr_o  = issue ? next_addr_q : addr_q;
   assign bus.valid_o       = (count_q != '0);
   assign bus.data_o        = bus.valid_o ? fifo_mem_q[rd_ptr_q] : '0;
   assign bus.busy_o        = (state_q == S_RUN);
   assign bus.done_o        = (state_q == S_DONE);
   assign bus.gbuff_wr_en_o = 1'b0;

endmodule

// File: tb/tb_gbuff_reader.sv
// tb/tb_gbuff_reader.sv - directed vector bench for gbuff_reader
module tb_gbuff_reader;
   localparam int AW    = 8;
   localparam int WW    = 16;
   localparam int LW    = 16;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [WW-1:0] buf_mem [256];

   always #5 clk = ~clk;

   gbuff_reader_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .LEN_WIDTH(LW)) bus ();

`ifdef GBUFF_READER_ABORT_EN
   logic abort_i = 1'b0;
`endif

   gbuff_reader #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
`ifdef GBUFF_READER_ABORT_EN
      .abort_i(abort_i),
`endif
      .bus    (bus)
   );

   // Buffer with one-cycle registered read latency
   always @(posedge clk) bus.gbuff_data_i <= buf_mem[bus.gbuff_addr_o];

   typedef struct {
      logic [AW-1:0] base;
      logic [LW-1:0] len;
      logic [AW-1:0] stride;
      int            mode;      // 0 ready high, 1 toggling, 2 held low through cycle 10
      bit            poke;      // extra start while busy
      logic [WW-1:0] exp_first;
      logic [WW-1:0] exp_last;
      int            exp_done;  // -1 when not hand-computed
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic rdy(input int mode, input int c);
      case (mode)
         0:       return 1'b1;
         1:       return (c % 2) == 0;
         default: return c > 10;
      endcase
   endfunction

   function automatic logic [WW-1:0] exp_word(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                                              input int i);
      logic [AW-1:0] a;
      a = base + AW'(i) * stride;
      return WW'(a) + WW'(16'h10);
   endfunction

   task automatic run_vec(input vec_t v);
      int c, words, done_cyc, first_valid, max_cnt;
      logic wr_seen;
      logic [AW-1:0] prev_addr;
      logic [WW-1:0] d;
      @(negedge clk);
      prev_addr = bus.gbuff_addr_o;
      bus.start_i = 1'b1;
      bus.base_addr_i = v.base;
      bus.len_i = v.len;
      bus.stride_i = v.stride;
      bus.ready_i = rdy(v.mode, 0);
      c = 0; words = 0; done_cyc = -1; first_valid = -1; max_cnt = 0; wr_seen = 1'b0;
      while (done_cyc < 0 && c < 200) begin
         @(negedge clk);
         c++;
         bus.start_i = v.poke && (c == 2);
         if (c == 2 && v.poke) begin
            bus.base_addr_i = 8'd100;
            bus.len_i = 16'd2;
         end
         bus.ready_i = rdy(v.mode, c);
         #1;
         if (bus.gbuff_wr_en_o !== 1'b0) wr_seen = 1'b1;
         if (int'(dut.count_q) > max_cnt) max_cnt = int'(dut.count_q);
         if (c == 1 && v.len != 0) chk("busy_c1", bus.busy_o, 1);
         if (bus.valid_o && first_valid < 0) first_valid = c;
         if (v.mode == 2 && c >= 3 && c <= 10) chk("hold_stable", bus.data_o, v.exp_first);
         if (v.mode == 2 && c == 10) begin
            chk("hold_valid", bus.valid_o, 1);
            chk("hold_addr", bus.gbuff_addr_o, v.base + AW'(DEPTH - 1) * v.stride);
         end
         if (bus.valid_o && bus.ready_i) begin
            d = bus.data_o;
            chk($sformatf("data[%0d]", words), d, exp_word(v.base, v.stride, words));
            if (words == 0) chk("first_word", d, v.exp_first);
            if (words == int'(v.len) - 1) chk("last_word", d, v.exp_last);
            words++;
         end
         if (bus.done_o) begin
            done_cyc = c;
            chk("busy_at_done", bus.busy_o, 0);
         end
      end
      chk("done_seen", done_cyc >= 0, 1);
      chk("word_count", words, v.len);
      if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
      if (v.len != 0) chk("first_valid_cycle", first_valid, 3);
      if (v.len == 0) chk("len0_no_issue", bus.gbuff_addr_o, prev_addr);
      chk("max_count", max_cnt <= DEPTH, 1);
      chk("wr_en_zero", wr_seen, 0);
      @(negedge clk);
      #1;
      chk("done_pulse", bus.done_o, 0);
      bus.ready_i = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic mid_stream_prep();
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.base_addr_i = 8'd0;
      bus.len_i = 16'd8;
      bus.stride_i = 8'd1;
      bus.ready_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("pre_kill_valid", bus.valid_o, 1);
   endtask

   task automatic post_kill_checks(input string tag);
      logic seen;
      @(negedge clk);
      #1;
      chk({tag, "_valid"}, bus.valid_o, 0);
      chk({tag, "_busy"}, bus.busy_o, 0);
      chk({tag, "_done"}, bus.done_o, 0);
      seen = 1'b0;
      rst_ni = 1'b1;
`ifdef GBUFF_READER_ABORT_EN
      abort_i = 1'b0;
`endif
      repeat (5) begin
         @(negedge clk);
         #1;
         if (bus.done_o || bus.valid_o) seen = 1'b1;
      end
      chk({tag, "_quiet"}, seen, 0);
   endtask

   initial begin
      vec_t after;
      for (int a = 0; a < 256; a++) buf_mem[a] = WW'(a + 16'h10);
      bus.start_i = 1'b0;
      bus.base_addr_i = '0;
      bus.len_i = '0;
      bus.stride_i = '0;
      bus.ready_i = 1'b1;

      vecs[0] = '{8'd0,   16'd8, 8'd1,   0, 1'b0, 16'h010, 16'h017, 11};
      vecs[1] = '{8'd254, 16'd4, 8'd1,   0, 1'b0, 16'h10E, 16'h011, 7};
      vecs[2] = '{8'd0,   16'd5, 8'd3,   1, 1'b0, 16'h010, 16'h01C, -1};
      vecs[3] = '{8'd0,   16'd8, 8'd1,   2, 1'b0, 16'h010, 16'h017, 19};
      vecs[4] = '{8'd0,   16'd0, 8'd1,   0, 1'b0, 16'h000, 16'h000, 1};
      vecs[5] = '{8'd0,   16'd4, 8'd1,   0, 1'b1, 16'h010, 16'h013, 7};
      vecs[6] = '{8'd16,  16'd6, 8'd255, 0, 1'b0, 16'h020, 16'h01B, 9};
      vecs[7] = '{8'd7,   16'd1, 8'd1,   0, 1'b0, 16'h017, 16'h017, 4};
      after   = '{8'd5,   16'd3, 8'd1,   0, 1'b0, 16'h015, 16'h017, 6};

      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_wr_en", bus.gbuff_wr_en_o, 0);
      chk("rst_addr", bus.gbuff_addr_o, 0);
      chk("rst_data", bus.data_o, 0);
      rst_ni = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      mid_stream_prep();
      rst_ni = 1'b0;
      post_kill_checks("reset");
      chk("reset_addr", bus.gbuff_addr_o, 0);
      run_vec(after);

`ifdef GBUFF_READER_ABORT_EN
      mid_stream_prep();
      abort_i = 1'b1;
      post_kill_checks("abort");
      run_vec(after);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
endmodule

// File: doc/gbuff_reader.md
# gbuff_reader

Read-side initiator for a global buffer (input, weight or output SRAM). The block takes a start command with base address, word count and address stride. It issues single-cycle read accesses on the buffer port and absorbs the buffer's one-cycle registered read latency in a credit-tracked FIFO. It delivers the words in order on a valid/ready stream toward the systolic-array feeder or the PS readback path.

## Interface
- `ADDR_WIDTH`, default `` `ADDR_WIDTH``: buffer address width.
- `WORD_WIDTH`, default `` `WORD_WIDTH``: buffer word width.
- `LEN_WIDTH`, default 16: width of the word-count field.
- `FIFO_DEPTH`, default 4: output FIFO entries; legal values are 2 or more, and 3 or more gives full throughput.
- `clk_i` input 1: the single clock.
- `rst_ni` input 1: reset, synchronous and active-low.
- `start_i` input 1: command strobe, sampled only while idle.
- `base_addr_i` input ADDR_WIDTH: first address to read.
- `len_i` input LEN_WIDTH: number of words to read.
- `stride_i` input ADDR_WIDTH: address increment per word.
- `busy_o` output 1: a command is active.
- `done_o` output 1: one-cycle pulse marking command completion.
- `gbuff_wr_en_o` output 1: buffer write enable; tied to 0.
- `gbuff_addr_o` output ADDR_WIDTH: buffer address.
- `gbuff_data_i` input WORD_WIDTH: buffer read data, valid the cycle after the address.
- `data_o` output WORD_WIDTH: stream data (FIFO head).
- `valid_o` output 1: stream valid.
- `ready_i` input 1: stream ready.

## Operation
- States:
  - IDLE → RUN on `start_i` with `len_i` nonzero.
  - IDLE → DONE on `start_i` with `len_i` equal to 0.
  - RUN → DONE in the cycle the last word handshakes (`valid_o && ready_i`).
  - DONE → IDLE unconditionally; `done_o` is high for that one cycle.
- `start_i` in RUN or DONE is ignored. `base_addr_i`, `len_i` and `stride_i` are captured at the accepted start.
- Counters:
  - `issue_cnt` counts reads issued.
  - `pop_cnt` counts words handshaked.
  - `count` is the current FIFO occupancy.
  - `inflight` is 1 when a read was issued the previous cycle.
- Issue rule: a read is issued in a cycle iff state is RUN, `issue_cnt < len`, and `count + inflight < FIFO_DEPTH`.
- On issue, `gbuff_addr_o` carries the address for word i, which is base + i·stride, modulo 2^ADDR_WIDTH (wrap-around is legal).
- When no read is issued, `gbuff_addr_o` holds its last value. The buffer still performs a read, but the returned data is not pushed.
- Push: when `inflight` is 1, `gbuff_data_i` is written to the FIFO tail at the end of that cycle.
- Pop: on `valid_o && ready_i`.
- Simultaneous push and pop leaves `count` unchanged.
- Overflow is impossible by the credit rule; the bench asserts that it never occurs.
- `valid_o` equals `count != 0`.
- `data_o` is stable while `valid_o && !ready_i`.
- `gbuff_wr_en_o` is constant 0, so this block never writes.

## Timing
- Reset: all of the following are cleared on the next rising edge and hold while `rst_ni` is 0:
  - state is IDLE;
  - `busy_o`, `done_o`, `valid_o`, `gbuff_wr_en_o` are 0;
  - `gbuff_addr_o` and `data_o` are 0;
  - FIFO is emptied and `inflight` is cleared.
- Reset mid-command: the command is dropped, no `done_o` pulse is produced, and any in-flight read data is discarded.
- Start accepted in cycle 0:
  - `busy_o` is 1 from cycle 1.
  - First address is issued in cycle 1.
  - Data returns in cycle 2.
  - `valid_o` is first high in cycle 3.
- With `ready_i` held at 1: one word per cycle. The last word is at cycle len+2, `done_o` is at cycle len+3, and `busy_o` falls at cycle len+3.
- `len_i` equal to 0: `done_o` in cycle 1 and no reads are issued.
- Backpressure: issue stalls once `count + inflight` reaches FIFO_DEPTH. It resumes the cycle after a pop frees a credit, with no data loss or duplication.

## Configuration
- `GBUFF_READER_ABORT_EN` defined: adds port `abort_i` (input, 1 bit).
  - Asserting `abort_i` in RUN stops issuing, empties the FIFO, and discards the in-flight word.
  - `valid_o` and `busy_o` are 0 from the next cycle, and the state returns to IDLE.
  - No `done_o` pulse is produced.
  - `abort_i` in IDLE has no effect.
  - When `abort_i` and `start_i` are both high in IDLE, the start is accepted.
- `GBUFF_READER_ABORT_EN` undefined: no `abort_i` port, and commands always run to completion.

## Test plan
- Preload buffer addresses 0–7 with 0x10–0x17; start with base 0, len 8, stride 1, `ready_i` held at 1 → `data_o` shows 0x10..0x17 on cycles 3–10, `done_o` in cycle 11, `gbuff_wr_en_o` always 0.
- Base 2^ADDR_WIDTH−2, len 4, stride 1 → reads addresses max−1, max, 0, 1 in order.
- Stride 3, len 5, `ready_i` toggling 1/0 every cycle → exactly 5 words, in order, at addresses 0, 3, 6, 9, 12, with no duplicates; `count` never exceeds FIFO_DEPTH.
- Hold `ready_i` at 0 for 10 cycles after start → at most FIFO_DEPTH reads issued, `valid_o` held with `data_o` stable; release `ready_i` → remaining words stream at one per cycle.
- Start with len 0 → `done_o` in cycle 1, no reads issued; a second `start_i` asserted while busy is ignored.
- Assert `rst_ni` low in mid-stream, and separately `abort_i` when the macro is defined → FIFO empty and `valid_o` 0 from the next cycle, no `done_o`; a new command afterwards returns correct data.
